// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with frame-aligned double buffer
module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 16,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic [6:0]  seg,
  output logic [3:0]  ga,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? (GUARD - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       digit, digit_nxt;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic             boundary;

  logic             pend;
  logic [15:0]      pend_data, act_data;
  logic [3:0]       pend_mask, act_mask;
  logic             accept, swap;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Scan state register: current phase, digit being served and dwell/guard counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      digit <= 2'd0;
      presc <= '0;
    end else begin
      state <= state_nxt;
      digit <= digit_nxt;
      presc <= presc_nxt;
    end
  end

  // Next-state logic; boundary marks the edge that closes digit 3's lit window
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    presc_nxt = presc;
    boundary  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      digit_nxt = 2'd0;
      presc_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SCAN;
          digit_nxt = 2'd0;
          presc_nxt = '0;
        end
        SCAN: begin
          if (presc == DIV_LAST) begin
            presc_nxt = '0;
            boundary  = (digit == 2'd3);
            if (GUARD > 0) begin
              state_nxt = BLANK;
            end else begin
              digit_nxt = digit + 2'd1;
            end
          end else begin
            presc_nxt = presc + CNT_ONE;
          end
        end
        BLANK: begin
          if (presc == GUARD_LAST) begin
            state_nxt = SCAN;
            digit_nxt = digit + 2'd1;
            presc_nxt = '0;
          end else begin
            presc_nxt = presc + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          digit_nxt = 2'd0;
          presc_nxt = '0;
        end
      endcase
    end
  end

  assign accept = wr_valid && wr_ready;
  // While idle nothing is on screen, so a pending word may be promoted at once
  assign swap   = pend && (boundary || (state == IDLE));

  // Write buffer: accept into pending slot, promote to active only at a frame edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      wr_ready  <= 1'b1;
      pend_data <= 16'h0000;
      pend_mask <= 4'b0000;
      act_data  <= 16'h0000;
      act_mask  <= 4'b0000;
    end else if (accept) begin
      pend      <= 1'b1;
      wr_ready  <= 1'b0;
      pend_data <= wr_data;
      pend_mask <= wr_mask;
    end else if (swap) begin
      pend      <= 1'b0;
      wr_ready  <= 1'b1;
      act_data  <= pend_data;
      act_mask  <= pend_mask;
    end
  end

  // Pin drivers: registered from the current scan state, gated by en so disable blanks next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'b1111111;
      ga         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (en && (state == SCAN)) begin
        ga  <= ~(4'b0001 << digit);
        seg <= act_mask[digit] ? decode(act_data[{digit, 2'b00} +: 4]) : 7'b1111111;
      end else begin
        ga  <= 4'b1111;
        seg <= 7'b1111111;
      end
    end
  end

endmodule
